mem_stage_dbus: RTL and testbench

- MEM pipeline stage. Consumes the registered EX/MEM outputs (mem_*) and drives the MEM/WB register inputs.
- Performs load/store accesses over a req/ack data bus.
- Handles big-endian byte/half/word alignment and detects address-alignment exceptions.
- Requests a pipeline stall while a bus transaction is outstanding.

---
 rtl/mem_stage_dbus_pkg.sv | 33 +++
 rtl/mem_stage_dbus_lane_align.sv | 88 ++++++++
 rtl/mem_stage_dbus.sv | 127 ++++++++++++
 tb/tb_mem_stage_dbus.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_dbus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_dbus_pkg : shared opcodes, exception bit indices and FSM states
// Revision 1.0
// ----------------------------------------------------------------------------
package mem_stage_dbus_pkg;

  localparam logic [7:0] c_EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] c_EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] c_EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] c_EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] c_EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] c_EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] c_EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] c_EXE_SW_OP  = 8'hEB;

  localparam int c_ADEL_BIT = 4;
  localparam int c_ADES_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Big-endian: byte 0 lives in the most significant lane (sel bit 3).
  function automatic logic [3:0] byte_sel(input logic [1:0] off);
    return 4'b1000 >> off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dbus_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_lane_align : big-endian byte-lane mapping, store replication, load
//                  extraction and misalignment detection (combinational)
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_lane_align
  import mem_stage_dbus_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        is_load_o,
  output logic        misalign_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (off_i)
      2'd0:    w_byte = rdata_i[31:24];
      2'd1:    w_byte = rdata_i[23:16];
      2'd2:    w_byte = rdata_i[15:8];
      default: w_byte = rdata_i[7:0];
    endcase
  end

  assign w_half = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  always_comb begin
    is_mem_o   = 1'b0;
    is_load_o  = 1'b0;
    misalign_o = 1'b0;
    sel_o      = 4'b0000;
    wdata_o    = 32'h0;
    load_o     = 32'h0;
    case (aluop_i)
      c_EXE_LB_OP, c_EXE_LBU_OP: begin
        is_mem_o  = 1'b1;
        is_load_o = 1'b1;
        sel_o     = byte_sel(off_i);
        load_o    = (aluop_i == c_EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h0, w_byte};
      end
      c_EXE_LH_OP, c_EXE_LHU_OP: begin
        is_mem_o   = 1'b1;
        is_load_o  = 1'b1;
        misalign_o = off_i[0];
        sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
        load_o     = (aluop_i == c_EXE_LH_OP) ? {{16{w_half[15]}}, w_half}
                                              : {16'h0, w_half};
      end
      c_EXE_LW_OP: begin
        is_mem_o   = 1'b1;
        is_load_o  = 1'b1;
        misalign_o = (off_i != 2'd0);
        sel_o      = 4'b1111;
        load_o     = rdata_i;
      end
      c_EXE_SB_OP: begin
        is_mem_o = 1'b1;
        sel_o    = byte_sel(off_i);
        wdata_o  = {4{reg2_i[7:0]}};
      end
      c_EXE_SH_OP: begin
        is_mem_o   = 1'b1;
        misalign_o = off_i[0];
        sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o    = {2{reg2_i[15:0]}};
      end
      c_EXE_SW_OP: begin
        is_mem_o   = 1'b1;
        misalign_o = (off_i != 2'd0);
        sel_o      = 4'b1111;
        wdata_o    = reg2_i;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_dbus.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_dbus : MEM pipeline stage issuing loads/stores over a req/ack bus
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_stage_dbus
  import mem_stage_dbus_pkg::*;
#(
  parameter int DBUS_AW  = 32,
  parameter int ADEL_BIT = c_ADEL_BIT,
  parameter int ADES_BIT = c_ADES_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [4:0]         mem_wd,
  input  logic               mem_wreg,
  input  logic [31:0]        mem_wdata,
  input  logic [7:0]         mem_aluop,
  input  logic [31:0]        mem_mem_addr,
  input  logic [31:0]        mem_reg2,
  input  logic [31:0]        mem_exc,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic [31:0]        exc_o,
  output logic               stallreq_o,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [DBUS_AW-1:0] dbus_addr,
  output logic [3:0]         dbus_sel,
  output logic [31:0]        dbus_wdata,
  input  logic               dbus_ack,
  input  logic [31:0]        dbus_rdata
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q;
  logic        w_is_mem, w_is_load, w_misalign, w_blocked, w_issue;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_load, w_word_addr;

  mem_lane_align u_align (
    .aluop_i    (mem_aluop),
    .off_i      (mem_mem_addr[1:0]),
    .reg2_i     (mem_reg2),
    .rdata_i    (dbus_rdata),
    .is_mem_o   (w_is_mem),
    .is_load_o  (w_is_load),
    .misalign_o (w_misalign),
    .sel_o      (w_sel),
    .wdata_o    (w_wdata),
    .load_o     (w_load)
  );

  assign w_word_addr = {mem_mem_addr[31:2], 2'b00};
  assign w_blocked   = w_is_mem && (w_misalign || (mem_exc != 32'h0));
  assign wd_o        = mem_wd;
  assign exc_o       = mem_exc
                     | ({31'h0, w_misalign &&  w_is_load} << ADEL_BIT)
                     | ({31'h0, w_misalign && w_is_mem && !w_is_load} << ADES_BIT);

  always_comb begin
    state_d    = state_q;
    stallreq_o = 1'b0;
    wreg_o     = w_blocked ? 1'b0 : mem_wreg;
    wdata_o    = mem_wdata;
    w_issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          wreg_o = 1'b0;
        end else if (w_is_mem && !w_blocked) begin
          w_issue    = 1'b1;
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
        if (dbus_ack)   state_d = ST_DONE;
        else if (flush) state_d = ST_DRAIN;
      end
      ST_DONE: begin
        if (w_is_load) wdata_o = rdata_q;
        if (flush)     wreg_o  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        wreg_o = 1'b0;
        if (dbus_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus fields are captured at issue so they stay stable for the whole wait.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= 32'h0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_sel   <= 4'b0000;
      dbus_addr  <= '0;
      dbus_wdata <= 32'h0;
    end else begin
      state_q <= state_d;
      if (w_issue) begin
        dbus_req   <= 1'b1;
        dbus_we    <= !w_is_load;
        dbus_sel   <= w_sel;
        dbus_addr  <= w_word_addr[DBUS_AW-1:0];
        dbus_wdata <= w_wdata;
      end
      if (dbus_ack && ((state_q == ST_WAIT) || (state_q == ST_DRAIN))) begin
        dbus_req <= 1'b0;
        dbus_we  <= 1'b0;
      end
      if (dbus_ack && (state_q == ST_WAIT)) rdata_q <= w_load;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dbus.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_stage_dbus : directed scoreboard bench for mem_stage_dbus
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mem_stage_dbus;

  localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4,
                         LHU = 8'hE5, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB,
                         ADDU = 8'h21;

  logic        clk = 1'b0;
  logic        rst, flush, mem_wreg, dbus_ack;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, mem_exc, dbus_rdata;
  logic [7:0]  mem_aluop;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, dbus_req, dbus_we;
  logic [31:0] wdata_o, exc_o, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_sel;
  logic        tb_valid;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] exc;
  } res_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  res_t mon_r;
  bus_t mon_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_dbus #(.DBUS_AW(32), .ADEL_BIT(4), .ADES_BIT(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_exc(mem_exc),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_o(exc_o),
    .stallreq_o(stallreq_o),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: writeback leaves whenever an instruction is present and not stalled.
  always @(negedge clk) begin
    if (rst) begin
      if (tb_valid && !stallreq_o) begin
        if (res_q.size() == 0) begin
          check("wb_underflow", 32'd1, 32'd0);
        end else begin
          mon_r = res_q.pop_front();
          check("wb_wd",    {27'h0, wd_o},   {27'h0, mon_r.wd});
          check("wb_wreg",  {31'h0, wreg_o}, {31'h0, mon_r.wreg});
          check("wb_wdata", wdata_o,         mon_r.wdata);
          check("wb_exc",   exc_o,           mon_r.exc);
        end
      end
      if (dbus_req) begin
        if (bus_q.size() == 0) begin
          check("bus_unexpected_req", 32'd1, 32'd0);
        end else begin
          mon_b = bus_q[0];
          check("bus_we",    {31'h0, dbus_we},  {31'h0, mon_b.we});
          check("bus_addr",  dbus_addr,         mon_b.addr);
          check("bus_sel",   {28'h0, dbus_sel}, {28'h0, mon_b.sel});
          check("bus_wdata", dbus_wdata,        mon_b.wdata);
          if (dbus_ack) void'(bus_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [31:0] wdata,
                       input logic [4:0] wd, input logic wreg,
                       input logic [31:0] exc);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg; mem_exc = exc;
  endtask

  task automatic nop();
    drive(8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    tb_valid = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction has left.
  task automatic mem_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] wdata_in,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] exc_in, input bit has_bus,
                        input int d, input logic [31:0] rdata,
                        input logic [3:0] e_sel, input logic [31:0] e_bwdata,
                        input logic e_wreg, input logic [31:0] e_wdata,
                        input logic [31:0] e_exc, input string name);
    int stalls;
    bus_t eb;
    res_t er;
    stalls = 0;
    drive(op, addr, reg2, wdata_in, wd, wreg, exc_in);
    tb_valid = 1'b1;
    er = '{wd: wd, wreg: e_wreg, wdata: e_wdata, exc: e_exc};
    res_q.push_back(er);
    if (has_bus) begin
      eb = '{we: (op == SB || op == SH || op == SW), addr: {addr[31:2], 2'b00},
             sel: e_sel, wdata: e_bwdata};
      bus_q.push_back(eb);
    end
    @(negedge clk); if (stallreq_o) stalls++;
    @(posedge clk); #1;
    if (has_bus) begin
      for (int k = 0; k <= d; k++) begin
        dbus_ack   = (k == d);
        dbus_rdata = (k == d) ? rdata : 32'hDEAD_BEEF;
        @(negedge clk); if (stallreq_o) stalls++;
        @(posedge clk); #1;
      end
      dbus_ack = 1'b0;
      @(negedge clk); if (stallreq_o) stalls++;
      @(posedge clk); #1;
    end
    check({name, "_stall_cycles"}, stalls, has_bus ? d + 2 : 0);
    nop();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {31'h0, dbus_req},   32'h0);
    check("rst_we",    {31'h0, dbus_we},    32'h0);
    check("rst_sel",   {28'h0, dbus_sel},   32'h0);
    check("rst_addr",  dbus_addr,           32'h0);
    check("rst_wdata", dbus_wdata,          32'h0);
    check("rst_stall", {31'h0, stallreq_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    //     op   addr          reg2          wdata_in      wd  wreg exc   bus d rdata         sel      bwdata        ewreg ewdata        eexc
    mem_op(LB,  32'h0000_0103, 32'h0,        32'h0000_0103, 3, 1, 32'h0, 1, 0, 32'h1122_33F4, 4'b0001, 32'h0,        1, 32'hFFFF_FFF4, 32'h0,  "lb");
    mem_op(SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0000_0202, 0, 0, 32'h0, 1, 3, 32'h0,        4'b0011, 32'hABCD_ABCD, 0, 32'h0000_0202, 32'h0,  "sh");
    mem_op(LW,  32'h0000_0101, 32'h0,        32'h0000_0101, 4, 1, 32'h0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0000_0101, 32'h10, "lw_adel");
    mem_op(SW,  32'h0000_0102, 32'h5555_5555, 32'h0000_0102, 0, 0, 32'h0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0000_0102, 32'h20, "sw_ades");
    mem_op(LHU, 32'h0000_0100, 32'h0,        32'h0000_0100, 5, 1, 32'h0, 1, 1, 32'h8001_FFFF, 4'b1100, 32'h0,        1, 32'h0000_8001, 32'h0,  "lhu");
    mem_op(LH,  32'h0000_0100, 32'h0,        32'h0000_0100, 6, 1, 32'h0, 1, 0, 32'h8001_FFFF, 4'b1100, 32'h0,        1, 32'hFFFF_8001, 32'h0,  "lh");
    mem_op(LBU, 32'h0000_0101, 32'h0,        32'h0000_0101, 8, 1, 32'h0, 1, 0, 32'h11A2_3344, 4'b0100, 32'h0,        1, 32'h0000_00A2, 32'h0,  "lbu");
    mem_op(SB,  32'h0000_0203, 32'h1234_565A, 32'h0000_0203, 0, 0, 32'h0, 1, 2, 32'h0,        4'b0001, 32'h5A5A_5A5A, 0, 32'h0000_0203, 32'h0,  "sb");
    mem_op(LW,  32'h0000_0500, 32'h0,        32'h0000_0500, 9, 1, 32'h1, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0000_0500, 32'h1,  "lw_exc");

    // Flush while waiting: the bus must drain without any writeback.
    drive(LW, 32'h0000_0300, 32'h0, 32'h0, 5'd10, 1'b1, 32'h0);
    tb_valid = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h300, sel: 4'b1111, wdata: 32'h0});
    @(negedge clk); check("fl_issue_stall", {31'h0, stallreq_o}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk); check("fl_wait_req", {31'h0, dbus_req}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(ADDU, 32'h0, 32'h0, 32'h55, 5'd11, 1'b1, 32'h0);
    tb_valid = 1'b0;
    @(negedge clk);
    check("fl_drain_req",   {31'h0, dbus_req},   32'h1);
    check("fl_drain_wreg",  {31'h0, wreg_o},     32'h0);
    check("fl_drain_stall", {31'h0, stallreq_o}, 32'h0);
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'h7777_7777;
    @(negedge clk); check("fl_drain2_wreg", {31'h0, wreg_o}, 32'h0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    nop();
    @(negedge clk); check("fl_after_req", {31'h0, dbus_req}, 32'h0);
    @(posedge clk); #1;
    mem_op(LW,  32'h0000_0304, 32'h0,        32'h0,         12, 1, 32'h0, 1, 1, 32'hCAFE_BABE, 4'b1111, 32'h0,        1, 32'hCAFE_BABE, 32'h0,  "lw_after_flush");

    // Reset in WAIT abandons the transaction.
    drive(LW, 32'h0000_0400, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0);
    tb_valid = 1'b1;
    bus_q.push_back('{we: 1'b0, addr: 32'h400, sel: 4'b1111, wdata: 32'h0});
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_req_before", {31'h0, dbus_req}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    check("rw_req_after",   {31'h0, dbus_req},   32'h0);
    check("rw_stall_after", {31'h0, stallreq_o}, 32'h0);
    rst = 1'b1;
    bus_q.delete();
    @(posedge clk); #1;

    // ack outside WAIT/DRAIN must not disturb a non-memory op.
    dbus_ack = 1'b1;
    mem_op(ADDU, 32'h0,       32'h0,        32'h1234_5678, 7, 1, 32'h0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 32'h1234_5678, 32'h0,  "addu");
    dbus_ack = 1'b0;
    @(negedge clk); check("stray_ack_req", {31'h0, dbus_req}, 32'h0);
    @(posedge clk); #1;
    mem_op(LB,  32'h0000_0100, 32'h0,        32'h0,         14, 1, 32'h0, 1, 0, 32'h8122_3344, 4'b1000, 32'h0,        1, 32'hFFFF_FF81, 32'h0,  "lb_after_rst");

    repeat (2) @(posedge clk);
    check("res_q_empty", res_q.size(), 32'd0);
    check("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
